// File: rtl/acc_adder_tree.sv
// acc_adder_tree: pipelined signed adder tree with per-lane masking, valid
// tracking, multi-beat accumulation and a rounded, saturated result.
// Beats are reduced by a binary tree, folded into an accumulator across a
// group, and the closing beat is requantised (round half up, then clip).
module acc_adder_tree #(
  parameter int DATA_W      = 16,
  parameter int DATA_N      = 32,
  parameter int LVL_PER_STG = 1,
  parameter int ACC_W       = 32,
  parameter int OUT_W       = 16,
  parameter int SH_W        = 5
) (
  input  logic                           clk,
  input  logic                           rst_n,
  input  logic                           in_valid,
  input  logic                           in_first,
  input  logic                           in_last,
  input  logic [DATA_N-1:0]              in_mask,
  input  logic [DATA_N-1:0][DATA_W-1:0]  vec,
  input  logic [SH_W-1:0]                shift,
  output logic                           out_valid,
  output logic signed [OUT_W-1:0]        out_sum,
  output logic                           out_sat,
  output logic                           out_drop
);

  localparam int L      = $clog2(DATA_N);
  localparam int TREE_W = DATA_W + L;
  localparam int NSTG   = (L + LVL_PER_STG - 1) / LVL_PER_STG;

  localparam logic signed [ACC_W:0] OUT_MAX = (ACC_W+1)'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [ACC_W:0] OUT_MIN = -OUT_MAX - (ACC_W+1)'(1);

  // Operand count remaining after a given number of pairwise levels.
  function automatic int lvl_cnt(input int lvl);
    int n;
    n = DATA_N;
    for (int k = 0; k < lvl; k++) n = (n + 1) / 2;
    return n;
  endfunction

  typedef struct packed {
    logic            valid;
    logic            first;
    logic            last;
    logic [SH_W-1:0] sh;
  } ctl_t;

  // ---------------------------------------------------------------- control
  ctl_t ctl_d [0:NSTG];
  ctl_t ctl_q [0:NSTG];

  // Control fields ride one slot per pipeline register, in lockstep with data.
  always_comb begin
    ctl_d[0].valid = in_valid;
    ctl_d[0].first = in_first;
    ctl_d[0].last  = in_last;
    ctl_d[0].sh    = shift;
    for (int s = 1; s <= NSTG; s++) ctl_d[s] = ctl_q[s-1];
  end

  // Control pipeline register; clearing valids on reset drops in-flight beats.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbours regardless of evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s <= NSTG; s++) ctl_q[s] <= '0;
    end else begin
      ctl_q <= ctl_d;
    end
  end

  // ---------------------------------------------------------------- tree
  logic signed [TREE_W-1:0] lane_d [DATA_N];

  // Mask and sign-extend each lane ahead of the input register.
  always_comb begin
    for (int i = 0; i < DATA_N; i++)
      lane_d[i] = in_mask[i] ? TREE_W'($signed(vec[i])) : '0;
  end

  for (genvar l = 0; l <= L; l++) begin : g_lvl
    localparam int CNT = lvl_cnt(l);
    logic signed [TREE_W-1:0] node [CNT];

    if (l == 0) begin : g_in
      logic signed [TREE_W-1:0] node_q [CNT];
      // Input lane register.
      // NOTE: data flops carry no reset; nothing downstream looks at them
      // unless the matching valid bit, which is reset, says so.
      always_ff @(posedge clk) node_q <= lane_d;
      assign node = node_q;
    end else begin : g_red
      localparam int  PCNT   = lvl_cnt(l - 1);
      localparam bit  IS_REG = ((l % LVL_PER_STG) == 0) || (l == L);
      logic signed [TREE_W-1:0] sum_d [CNT];

      // Pairwise add; an odd leftover operand passes through unchanged.
      for (genvar i = 0; i < CNT; i++) begin : g_op
        if (2 * i + 1 < PCNT) begin : g_add
          assign sum_d[i] = g_lvl[l-1].node[2*i] + g_lvl[l-1].node[2*i+1];
        end else begin : g_pass
          assign sum_d[i] = g_lvl[l-1].node[2*i];
        end
      end

      if (IS_REG) begin : g_reg
        logic signed [TREE_W-1:0] node_q [CNT];
        // Stage register closing a group of LVL_PER_STG levels.
        always_ff @(posedge clk) node_q <= sum_d;
        assign node = node_q;
      end else begin : g_comb
        assign node = sum_d;
      end
    end
  end

  logic signed [TREE_W-1:0] tree_sum;
  assign tree_sum = g_lvl[L].node[0];

  // ---------------------------------------------------------------- accumulator
  ctl_t                    top;
  logic signed [ACC_W-1:0] tree_ext;
  logic signed [ACC_W-1:0] acc_d, acc_q;
  logic                    open_d, open_q;
  logic                    drop_d, drop_q;
  logic                    fin_d, fin_q;
  logic [SH_W-1:0]         fin_sh_d, fin_sh_q;

  assign top      = ctl_q[NSTG];
  assign tree_ext = ACC_W'(tree_sum);

  // Fold a valid beat into the group; a first beat (or a stray continuation
  // with no open group) restarts it, abandoning any open partial sum.
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    acc_d    = acc_q;
    open_d   = open_q;
    drop_d   = 1'b0;
    fin_d    = 1'b0;
    fin_sh_d = fin_sh_q;
    if (top.valid) begin
      if (top.first || !open_q) acc_d = tree_ext;
      else                      acc_d = acc_q + tree_ext;
      drop_d   = top.first && open_q;
      open_d   = !top.last;
      fin_d    = top.last;
      fin_sh_d = top.sh;
    end
  end

  // Accumulator and group state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q    <= '0;
      open_q   <= 1'b0;
      drop_q   <= 1'b0;
      fin_q    <= 1'b0;
      fin_sh_q <= '0;
    end else begin
      acc_q    <= acc_d;
      open_q   <= open_d;
      drop_q   <= drop_d;
      fin_q    <= fin_d;
      fin_sh_q <= fin_sh_d;
    end
  end

  // ---------------------------------------------------------------- output
  logic [31:0]              sh_amt;
  logic signed [ACC_W:0]    acc_x, rnd, rsum, res;
  logic signed [OUT_W-1:0]  sat_val;
  logic                     sat_flag;
  logic                     out_valid_d, out_valid_q;
  logic signed [OUT_W-1:0]  out_sum_d, out_sum_q;
  logic                     out_sat_d, out_sat_q;

  // Round half up in ACC_W+1 bits so the bias add cannot wrap, then clip.
  always_comb begin
    sh_amt   = 32'(fin_sh_q);
    acc_x    = (ACC_W+1)'(acc_q);
    rnd      = '0;
    rsum     = acc_x;
    res      = acc_x;
    if (sh_amt >= 32'(ACC_W)) begin
      res = acc_q[ACC_W-1] ? '1 : '0;
    end else if (sh_amt != 32'd0) begin
      rnd  = (ACC_W+1)'(1) << (sh_amt - 32'd1);
      rsum = acc_x + rnd;
      res  = rsum >>> sh_amt;
    end
    sat_val  = res[OUT_W-1:0];
    sat_flag = 1'b0;
    if (res > OUT_MAX) begin
      sat_val  = OUT_MAX[OUT_W-1:0];
      sat_flag = 1'b1;
    end else if (res < OUT_MIN) begin
      sat_val  = OUT_MIN[OUT_W-1:0];
      sat_flag = 1'b1;
    end
    out_valid_d = fin_q;
    out_sum_d   = fin_q ? sat_val  : out_sum_q;
    out_sat_d   = fin_q ? sat_flag : out_sat_q;
  end

  // Output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_sat_q   <= 1'b0;
    end else begin
      out_valid_q <= out_valid_d;
      out_sum_q   <= out_sum_d;
      out_sat_q   <= out_sat_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_sat   = out_sat_q;
  assign out_drop  = drop_q;

endmodule

// File: doc/acc_adder_tree.md
# acc_adder_tree

Pipelined signed adder tree with valid tracking, lane masking, multi-beat accumulation and a rounded, saturated output. It sits in the PE datapath behind the multiplier array. It reduces DATA_N products per cycle and accumulates partial sums across beats, for example over the input-channel loop. The final requantised result is emitted once per accumulation group. It generalises the fixed single-beat reduction used so far in the following ways:
- arbitrary lane count
- configurable register spacing
- per-lane mask
- valid pipeline
- accumulation
- output scaling

## Interface
- DATA_W, 16, signed lane width.
- DATA_N, 32, lane count; any value ≥ 2, not restricted to powers of two.
- LVL_PER_STG, 1, tree levels per pipeline register (1..L).
- ACC_W, 32, accumulator width; must be ≥ TREE_W.
- OUT_W, 16, signed output width.
- SH_W, 5, width of the shift input.
- Derived constants:
  - L = ceil(log2(DATA_N))
  - TREE_W = DATA_W + L
  - T = 1 + ceil(L / LVL_PER_STG)
- clk  in  1  clock; all logic is on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  the beat on vec is valid this cycle.
- in_first  in  1  first beat of an accumulation group; qualified by in_valid.
- in_last  in  1  last beat of a group; may be high together with in_first.
- in_mask  in  DATA_N  per-lane enable; a 0 bit forces that lane to zero.
- vec  in  DATA_N×DATA_W  packed signed lanes; lane i is vec[i].
- shift  in  SH_W  right-shift amount; sampled on the in_valid & in_last beat.
- out_valid  out  1  single-cycle result strobe.
- out_sum  out  OUT_W  rounded, saturated result.
- out_sat  out  1  out_sum was clipped; valid with out_valid.
- out_drop  out  1  one-cycle pulse: an open group was abandoned by a new in_first.

## Operation
- Input stage:
  - Registers each lane as vec[i] & {DATA_W{in_mask[i]}}, sign-extended to TREE_W.
  - Registers in_valid, in_first, in_last and shift alongside the lanes.
- Tree:
  - Pairwise binary reduction over L levels.
  - Odd leftover operands pass through a level unchanged.
  - A register follows every LVL_PER_STG levels and after the final level; levels between registers are combinational.
- Control pipeline:
  - valid, first, last and shift travel in lockstep with the data through all T stages.
  - Bubbles (in_valid = 0) propagate as invalid slots.
  - Invalid slots never modify the accumulator.
- Accumulator (acc, ACC_W bits, plus open flag):
  - Valid beat with first set: acc ← sext(tree). If open was already 1, pulse out_drop and discard the old partial sum.
  - Valid beat with first clear and open = 1: acc ← acc + sext(tree), two's-complement wrap.
  - Valid beat with first clear and open = 0: treated as a first beat (acc ← sext(tree)); no drop pulse.
  - open ← 1 on every valid beat without last, and 0 on every valid beat with last.
  - The in_last beat updates acc, and the updated value goes to the output stage.
- Output stage, applied to the final acc value, with s = shift carried with the last beat:
  - If s > 0: r = (acc + 2^(s−1)) >>> s, arithmetic shift, round half up; computed in ACC_W+1 bits so the rounding add cannot wrap.
  - If s = 0: r = acc.
  - Saturate r to [−2^(OUT_W−1), 2^(OUT_W−1)−1]; out_sat = 1 when clipped.
  - s ≥ ACC_W yields 0 for non-negative acc and −1 for negative acc (before rounding effects).
- Throughput: one beat per cycle, no backpressure. The consumer must always accept out_valid.

## Timing
- Reset values (asynchronous): every pipeline valid = 0, open = 0, acc = 0, out_valid = 0, out_sum = 0, out_sat = 0, out_drop = 0.
- Data registers may also be reset; outputs must not depend on them while the corresponding valid is 0.
- Pipeline timing, with beat k presented at cycle c:
  - Tree result at the accumulator input at c+T.
  - acc updated at the edge ending c+T.
  - out_valid / out_sum / out_sat registered at c+T+2.
- Latency from the in_last beat to out_valid is T+2 cycles:
  - DATA_N=32, LVL_PER_STG=1: T=6, latency 8.
  - DATA_N=32, LVL_PER_STG=2: T=4, latency 6.
- out_drop is asserted at c+T+1 for the offending in_first beat at cycle c.
- out_valid is high for exactly one cycle per completed group, and back-to-back single-beat groups give out_valid on consecutive cycles.
- Reset mid-group discards all partial sums and in-flight beats; no out_valid is produced for them.
- in_first, in_last, in_mask and shift are ignored when in_valid = 0.

## Test plan
- Reduction: DATA_N=32, all lanes = 1, mask all ones, first = last = 1, shift = 0.
  - out_valid exactly 8 cycles later, out_sum = 32, out_sat = 0.
- Negative extremes: all lanes = −32768, single beat, shift = 5.
  - acc = −1048576; out_sum = −32768, out_sat = 0.
  - With shift = 0 instead: out_sum = −32768, out_sat = 1.
- Odd lane count and mask: DATA_N=5, vec = {1, 2, 3, 4, 5}, mask = 5'b10101, single beat.
  - out_sum = 9.
  - Latency = 1 + 3 + 2 = 6 cycles.
- Accumulation with bubbles: 4 beats of all-ones (DATA_N=32) with first on beat 0, last on beat 3, and one idle cycle between beats 1 and 2, shift = 1.
  - One out_valid with out_sum = 64.
  - Rounding variant: total 3 with shift = 1 gives 2.
- Abandon and reset:
  - Open a group with 2 beats, then send a first+last beat of value 7 (one lane).
  - Required: out_drop pulse, then out_sum = 7.
  - Then start another group and assert rst_n low mid-group: no out_valid follows, and all outputs read 0 during reset.
- Throughput: 16 consecutive single-beat groups with distinct lane-0 values 0..15.
  - 16 consecutive out_valid cycles with values in order.
